// File: rtl/deser_pkg.sv
// Shared types and default sizing for the buffered deserializer.
package deser_pkg;

    // Control states of the deserializer front end.
    typedef enum logic [1:0] {
        INIT    = 2'd0,
        RECEIVE = 2'd1,
        FULL    = 2'd2
    } deser_state_t;

    localparam int DESER_WIDTH = 8;
    localparam int DESER_DEPTH = 2;

endpackage

// File: rtl/word_fifo.sv
// Small synchronous word FIFO. Pointers carry one extra wrap bit so a full
// buffer and an empty buffer are told apart without a separate counter.
module word_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  logic                       pop,
    input  logic [WIDTH-1:0]           wdata,
    output logic [WIDTH-1:0]           rdata,
    output logic                       empty,
    output logic                       full,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wr_ptr_q;
    logic [AW:0]      rd_ptr_q;

    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign count = wr_ptr_q - rd_ptr_q;

    // An empty buffer presents zero rather than stale storage contents.
    assign rdata = empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];

    // Pointer update; a push into a full buffer or a pop from an empty one is ignored.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (push && !full) wr_ptr_q <= wr_ptr_q + (AW+1)'(1);
            if (pop && !empty) rd_ptr_q <= rd_ptr_q + (AW+1)'(1);
        end
    end

    // Word storage; contents are only visible through rdata when not empty.
    always_ff @(posedge clk) begin
        if (push && !full) mem_q[wr_ptr_q[AW-1:0]] <= wdata;
    end

endmodule

// File: rtl/deserializer_buf.sv
// Serial-to-parallel converter with a DEPTH-word output buffer.
// Handshake: a bit is taken on a rising edge when write_in=1 and status_out=1;
// the head word is consumed on a rising edge when ack_in=1 and data_ready=1.
module deserializer_buf
    import deser_pkg::*;
#(
    parameter int WIDTH     = DESER_WIDTH,
    parameter int DEPTH     = DESER_DEPTH,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic                       clock_100KHZ,
    input  logic                       reset,
    input  logic                       data_in,
    input  logic                       write_in,
    input  logic                       ack_in,
    input  logic                       clear_in,
    output logic                       status_out,
    output logic [WIDTH-1:0]           data_out,
    output logic                       data_ready,
    output logic [$clog2(WIDTH)-1:0]   bit_count_out,
    output logic                       overrun_out
);

    localparam int BW = $clog2(WIDTH);
    localparam int CW = $clog2(DEPTH) + 1;

    deser_state_t   state_q, state_d;
    logic [WIDTH-1:0] shift_q, shift_d, word_d;
    logic [BW-1:0]  bit_cnt_q, bit_cnt_d;
    logic           overrun_q, overrun_d;
    logic           accept, push, pop;
    logic           fifo_empty, fifo_full;
    logic [CW-1:0]  fifo_count, count_d;

    // status_out is a pure decode of the registered state.
    assign status_out    = (state_q == RECEIVE);
    assign accept        = write_in && status_out && !clear_in;
    assign push          = accept && (bit_cnt_q == BW'(WIDTH-1)) && !fifo_full;
    assign pop           = ack_in && !fifo_empty;
    assign data_ready    = !fifo_empty;
    assign bit_count_out = bit_cnt_q;
    assign overrun_out   = overrun_q;

    // Shifter value with the incoming bit inserted, in the configured bit order.
    always_comb begin
        word_d = MSB_FIRST ? {shift_q[WIDTH-2:0], data_in}
                           : {data_in, shift_q[WIDTH-1:1]};
    end

    // Partial-word datapath: clear wins over a write; the final bit empties the shifter.
    always_comb begin
        shift_d   = shift_q;
        bit_cnt_d = bit_cnt_q;
        overrun_d = overrun_q | (write_in && !status_out);
        if (clear_in) begin
            shift_d   = '0;
            bit_cnt_d = '0;
            overrun_d = 1'b0;
        end else if (accept) begin
            if (push) begin
                shift_d   = '0;
                bit_cnt_d = '0;
            end else begin
                shift_d   = word_d;
                bit_cnt_d = bit_cnt_q + BW'(1);
            end
        end
    end

    // Next state from the buffer occupancy that this edge will leave behind.
    always_comb begin
        count_d = fifo_count + CW'(push) - CW'(pop);
        state_d = state_q;
        case (state_q)
            INIT:    state_d = RECEIVE;
            RECEIVE: if (count_d == CW'(DEPTH)) state_d = FULL;
            FULL:    if (pop) state_d = RECEIVE;
            default: state_d = INIT;
        endcase
    end

    // State, shifter, bit counter and sticky overrun registers.
    always_ff @(posedge clock_100KHZ or negedge reset) begin
        if (!reset) begin
            state_q   <= INIT;
            shift_q   <= '0;
            bit_cnt_q <= '0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            bit_cnt_q <= bit_cnt_d;
            overrun_q <= overrun_d;
        end
    end

    word_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_word_fifo (
        .clk   (clock_100KHZ),
        .rst_n (reset),
        .push  (push),
        .pop   (pop),
        .wdata (word_d),
        .rdata (data_out),
        .empty (fifo_empty),
        .full  (fifo_full),
        .count (fifo_count)
    );

endmodule

// File: tb/tb_deserializer_buf.sv
// Bench for deserializer_buf: one MSB-first and one LSB-first instance share
// the same stimulus; expected words are queued as bits are sent and compared
// when the words are acknowledged.
`timescale 1ns/1ps
module tb_deserializer_buf;

    localparam int W = 8;
    localparam int D = 2;

    logic clk = 1'b0;
    logic reset;
    logic data_in, write_in, ack_in, clear_in;

    logic         status_m, ready_m, ovr_m;
    logic [W-1:0] dout_m;
    logic [2:0]   cnt_m;
    logic         status_l, ready_l, ovr_l;
    logic [W-1:0] dout_l;
    logic [2:0]   cnt_l;

    int checks = 0;
    int errors = 0;

    logic [W-1:0] exp_m[$];
    logic [W-1:0] exp_l[$];
    int           m_bits;
    logic [W-1:0] m_wm, m_wl;
    int           m_state;
    logic         m_ovr;

    deserializer_buf #(.WIDTH(W), .DEPTH(D), .MSB_FIRST(1'b1)) dut_m (
        .clock_100KHZ (clk),      .reset      (reset),
        .data_in      (data_in),  .write_in   (write_in),
        .ack_in       (ack_in),   .clear_in   (clear_in),
        .status_out   (status_m), .data_out   (dout_m),
        .data_ready   (ready_m),  .bit_count_out (cnt_m),
        .overrun_out  (ovr_m)
    );

    deserializer_buf #(.WIDTH(W), .DEPTH(D), .MSB_FIRST(1'b0)) dut_l (
        .clock_100KHZ (clk),      .reset      (reset),
        .data_in      (data_in),  .write_in   (write_in),
        .ack_in       (ack_in),   .clear_in   (clear_in),
        .status_out   (status_l), .data_out   (dout_l),
        .data_ready   (ready_l),  .bit_count_out (cnt_l),
        .overrun_out  (ovr_l)
    );

    // Clock
    always #5 clk = ~clk;

    function automatic logic [W-1:0] rev(input logic [W-1:0] v);
        logic [W-1:0] r;
        for (int i = 0; i < W; i++) r[i] = v[W-1-i];
        return r;
    endfunction

    task automatic model_reset();
        exp_m.delete();
        exp_l.delete();
        m_bits  = 0;
        m_wm    = '0;
        m_wl    = '0;
        m_state = 0;
        m_ovr   = 1'b0;
    endtask

    // Driver: one clock of stimulus, model update, and scoreboard compare on pops.
    task automatic drive_cycle(input logic w, input logic d, input logic a, input logic c);
        logic st, pp, acc;
        write_in = w; data_in = d; ack_in = a; clear_in = c;
        st = (m_state == 1);
        pp = a && (exp_m.size() > 0);
        if (pp) begin
            checks++;
            if (dout_m !== exp_m[0] || dout_l !== exp_l[0] || ready_m !== 1'b1) begin
                errors++;
                $display("FAIL pop_word got msb=%h lsb=%h rdy=%b expected msb=%h lsb=%h rdy=1",
                         dout_m, dout_l, ready_m, exp_m[0], exp_l[0]);
            end
            void'(exp_m.pop_front());
            void'(exp_l.pop_front());
        end
        acc = w && st && !c;
        if (c) m_ovr = 1'b0;
        else if (w && !st) m_ovr = 1'b1;
        if (c) begin
            m_bits = 0; m_wm = '0; m_wl = '0;
        end else if (acc) begin
            m_wm[W-1-m_bits] = d;
            m_wl[m_bits]     = d;
            m_bits++;
            if (m_bits == W) begin
                exp_m.push_back(m_wm);
                exp_l.push_back(m_wl);
                m_bits = 0; m_wm = '0; m_wl = '0;
            end
        end
        if (m_state == 0) m_state = 1;
        else if (m_state == 1 && exp_m.size() == D) m_state = 2;
        else if (m_state == 2 && pp) m_state = 1;
        @(posedge clk);
        #1;
        write_in = 1'b0; data_in = 1'b0; ack_in = 1'b0; clear_in = 1'b0;
    endtask

    task automatic send_byte(input logic [W-1:0] v);
        for (int i = 0; i < W; i++) drive_cycle(1'b1, v[W-1-i], 1'b0, 1'b0);
    endtask

    task automatic test_reset();
        reset = 1'b0; data_in = 1'b0; write_in = 1'b0; ack_in = 1'b0; clear_in = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({status_m, ready_m, ovr_m, cnt_m, dout_m, status_l, ready_l, ovr_l, cnt_l, dout_l} !== '0) begin
            errors++;
            $display("FAIL reset_outputs got st=%b rdy=%b ovr=%b cnt=%0d dout=%h expected all 0",
                     status_m, ready_m, ovr_m, cnt_m, dout_m);
        end
        reset = 1'b1;
        checks++;
        if (status_m !== 1'b0 || status_l !== 1'b0) begin
            errors++;
            $display("FAIL init_status got %b/%b expected 0", status_m, status_l);
        end
        // A write while still in INIT is refused and flagged.
        drive_cycle(1'b1, 1'b1, 1'b0, 1'b0);
        checks++;
        if (status_m !== 1'b1 || status_l !== 1'b1 || ovr_m !== m_ovr || ovr_l !== m_ovr ||
            cnt_m !== 3'd0 || cnt_l !== 3'd0) begin
            errors++;
            $display("FAIL startup got st=%b ovr=%b cnt=%0d expected st=1 ovr=%b cnt=0",
                     status_m, ovr_m, cnt_m, m_ovr);
        end
        drive_cycle(1'b0, 1'b0, 1'b0, 1'b1);
        checks++;
        if (ovr_m !== 1'b0 || ovr_l !== 1'b0) begin
            errors++;
            $display("FAIL init_clear_overrun got %b/%b expected 0", ovr_m, ovr_l);
        end
    endtask

    task automatic test_bit_order();
        logic [W-1:0] bits;
        bits = 8'b1100_0000;
        for (int i = 0; i < 3; i++) drive_cycle(1'b1, bits[W-1-i], 1'b0, 1'b0);
        checks++;
        if (cnt_m !== 3'd3 || cnt_l !== 3'd3 || ready_m !== 1'b0) begin
            errors++;
            $display("FAIL partial_count got cnt=%0d rdy=%b expected cnt=3 rdy=0", cnt_m, ready_m);
        end
        for (int i = 3; i < W; i++) drive_cycle(1'b1, bits[W-1-i], 1'b0, 1'b0);
        checks++;
        if (ready_m !== 1'b1 || ready_l !== 1'b1 || dout_m !== 8'hC0 || dout_l !== 8'h03 || cnt_m !== 3'd0) begin
            errors++;
            $display("FAIL word_order got rdy=%b msb=%h lsb=%h cnt=%0d expected rdy=1 msb=c0 lsb=03 cnt=0",
                     ready_m, dout_m, dout_l, cnt_m);
        end
        drive_cycle(1'b0, 1'b0, 1'b1, 1'b0);
        checks++;
        if (ready_m !== 1'b0 || ready_l !== 1'b0 || dout_m !== 8'h00 || dout_l !== 8'h00) begin
            errors++;
            $display("FAIL ack_empty got rdy=%b msb=%h lsb=%h expected rdy=0 data 00", ready_m, dout_m, dout_l);
        end
        // Acknowledge with nothing buffered has no effect.
        drive_cycle(1'b0, 1'b0, 1'b1, 1'b0);
        checks++;
        if (ready_m !== 1'b0 || status_m !== 1'b1 || dout_m !== 8'h00) begin
            errors++;
            $display("FAIL idle_ack got rdy=%b st=%b dout=%h expected rdy=0 st=1 dout=00", ready_m, status_m, dout_m);
        end
    endtask

    task automatic test_full_overrun();
        send_byte(8'hA5);
        checks++;
        if (ready_m !== 1'b1 || status_m !== 1'b1) begin
            errors++;
            $display("FAIL one_word got rdy=%b st=%b expected 1/1", ready_m, status_m);
        end
        send_byte(8'h3C);
        checks++;
        if (status_m !== 1'b0 || status_l !== 1'b0 || dout_m !== 8'hA5 || ovr_m !== 1'b0) begin
            errors++;
            $display("FAIL full got st=%b dout=%h ovr=%b expected st=0 dout=a5 ovr=0", status_m, dout_m, ovr_m);
        end
        drive_cycle(1'b1, 1'b1, 1'b0, 1'b0);
        checks++;
        if (ovr_m !== 1'b1 || ovr_l !== 1'b1 || cnt_m !== 3'd0 || status_m !== 1'b0) begin
            errors++;
            $display("FAIL overrun got ovr=%b cnt=%0d st=%b expected ovr=1 cnt=0 st=0", ovr_m, cnt_m, status_m);
        end
        // Bit offered on the pop edge is refused because status_out was still low.
        drive_cycle(1'b1, 1'b1, 1'b1, 1'b0);
        checks++;
        if (dout_m !== 8'h3C || status_m !== 1'b1 || cnt_m !== 3'd0 || ovr_m !== 1'b1) begin
            errors++;
            $display("FAIL pop_reopen got dout=%h st=%b cnt=%0d ovr=%b expected dout=3c st=1 cnt=0 ovr=1",
                     dout_m, status_m, cnt_m, ovr_m);
        end
        drive_cycle(1'b0, 1'b0, 1'b0, 1'b1);
        checks++;
        if (ovr_m !== 1'b0 || ovr_l !== 1'b0 || ready_m !== 1'b1) begin
            errors++;
            $display("FAIL clear_overrun got ovr=%b rdy=%b expected ovr=0 rdy=1", ovr_m, ready_m);
        end
    endtask

    task automatic test_simultaneous();
        logic [W-1:0] v, u, y;
        v = W'($urandom_range(0, 255));
        u = W'($urandom_range(0, 255));
        y = W'($urandom_range(0, 255));
        for (int i = 0; i < W-1; i++) drive_cycle(1'b1, v[W-1-i], 1'b0, 1'b0);
        drive_cycle(1'b1, v[0], 1'b1, 1'b0);
        checks++;
        if (ready_m !== 1'b1 || status_m !== 1'b1 || dout_m !== v || dout_l !== rev(v) || cnt_m !== 3'd0) begin
            errors++;
            $display("FAIL push_pop got rdy=%b st=%b msb=%h lsb=%h expected rdy=1 st=1 msb=%h lsb=%h",
                     ready_m, status_m, dout_m, dout_l, v, rev(v));
        end
        for (int i = 0; i < 5; i++) drive_cycle(1'b1, u[W-1-i], 1'b0, 1'b0);
        checks++;
        if (cnt_m !== 3'd5 || cnt_l !== 3'd5) begin
            errors++;
            $display("FAIL count_five got %0d/%0d expected 5", cnt_m, cnt_l);
        end
        drive_cycle(1'b1, 1'b1, 1'b0, 1'b1);
        checks++;
        if (cnt_m !== 3'd0 || cnt_l !== 3'd0 || ready_m !== 1'b1 || status_m !== 1'b1 || dout_m !== v) begin
            errors++;
            $display("FAIL clear_write got cnt=%0d rdy=%b st=%b dout=%h expected cnt=0 rdy=1 st=1 dout=%h",
                     cnt_m, ready_m, status_m, dout_m, v);
        end
        send_byte(y);
        checks++;
        if (status_m !== 1'b0 || status_l !== 1'b0) begin
            errors++;
            $display("FAIL refill_full got st=%b/%b expected 0", status_m, status_l);
        end
        drive_cycle(1'b0, 1'b0, 1'b1, 1'b0);
        drive_cycle(1'b0, 1'b0, 1'b1, 1'b0);
        checks++;
        if (ready_m !== 1'b0 || ready_l !== 1'b0 || status_m !== 1'b1) begin
            errors++;
            $display("FAIL drain got rdy=%b st=%b expected rdy=0 st=1", ready_m, status_m);
        end
    endtask

    task automatic test_mid_reset();
        logic [W-1:0] r;
        send_byte(W'($urandom_range(0, 255)));
        send_byte(W'($urandom_range(0, 255)));
        drive_cycle(1'b1, 1'b0, 1'b0, 1'b0);
        drive_cycle(1'b0, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) drive_cycle(1'b1, 1'b1, 1'b0, 1'b0);
        checks++;
        if (cnt_m !== 3'd3 || ready_m !== 1'b1 || ovr_m !== 1'b1) begin
            errors++;
            $display("FAIL pre_reset got cnt=%0d rdy=%b ovr=%b expected cnt=3 rdy=1 ovr=1", cnt_m, ready_m, ovr_m);
        end
        #3;
        reset = 1'b0;
        #1;
        checks++;
        if ({status_m, ready_m, ovr_m, cnt_m, dout_m, status_l, ready_l, ovr_l, cnt_l, dout_l} !== '0) begin
            errors++;
            $display("FAIL async_reset got st=%b rdy=%b ovr=%b cnt=%0d dout=%h expected all 0",
                     status_m, ready_m, ovr_m, cnt_m, dout_m);
        end
        model_reset();
        @(posedge clk);
        #1;
        reset = 1'b1;
        drive_cycle(1'b0, 1'b0, 1'b0, 1'b0);
        checks++;
        if (status_m !== 1'b1 || status_l !== 1'b1) begin
            errors++;
            $display("FAIL restart_status got %b/%b expected 1", status_m, status_l);
        end
        r = W'($urandom_range(0, 255));
        send_byte(r);
        checks++;
        if (ready_m !== 1'b1 || dout_m !== r || dout_l !== rev(r) || cnt_m !== 3'd0) begin
            errors++;
            $display("FAIL restart_word got rdy=%b msb=%h lsb=%h expected rdy=1 msb=%h lsb=%h",
                     ready_m, dout_m, dout_l, r, rev(r));
        end
        drive_cycle(1'b0, 1'b0, 1'b1, 1'b0);
        checks++;
        if (ready_m !== 1'b0 || dout_m !== 8'h00) begin
            errors++;
            $display("FAIL restart_drain got rdy=%b dout=%h expected 0/00", ready_m, dout_m);
        end
    endtask

    initial begin
        test_reset();
        test_bit_order();
        test_full_overrun();
        test_simultaneous();
        test_mid_reset();
        checks++;
        if (exp_m.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_leftover got %0d words expected 0", exp_m.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
